instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning instruction word width in bits (minimum 4).
REQ-002 SHALL have parameter DEPTH, default 32, meaning number of instruction words stored.
REQ-003 SHALL have parameter ADDR_W, default 8, meaning width of every address and PC field.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port clear, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port prog_we, input, 1, program-write strobe.
REQ-007 SHALL have port prog_addr, input, ADDR_W, program-write address.
REQ-008 SHALL have port prog_data, input, WIDTH, program-write data.
REQ-009 SHALL have port run, input, 1, start-fetch pulse.
REQ-010 SHALL have port stall, input, 1, hold-current-fetch request from the consumer.
REQ-011 SHALL have port jump, input, 1, redirect request.
REQ-012 SHALL have port jump_addr, input, ADDR_W, redirect target.
REQ-013 SHALL have port instruction, output, WIDTH, registered fetched word.
REQ-014 SHALL have port pc, output, ADDR_W, address of the word currently on instruction.
REQ-015 SHALL have port valid, output, 1, instruction holds a fetched word this cycle.
REQ-016 SHALL have port halted, output, 1, a stop word was fetched.

Function
REQ-017 SHALL store DEPTH words of WIDTH bits in registers.
REQ-018 SHALL treat as a stop word any word whose two MSBs are 2'b11.
REQ-019 SHALL use STOP_WORD = {2'b11, zeros}, WIDTH bits wide.
REQ-020 SHALL implement states IDLE, FETCH, HALT.
REQ-021 In IDLE, a prog_we high with prog_addr < DEPTH SHALL write prog_data to that word at the next edge.
REQ-022 A prog_we high with prog_addr >= DEPTH SHALL be ignored.
REQ-023 prog_we SHALL be ignored in FETCH and in HALT.
REQ-024 IDLE or HALT with run=1 SHALL move to FETCH with the internal fetch pointer set to 0 and halted cleared.
REQ-025 In FETCH with stall=0, each edge SHALL load instruction with the word at the fetch pointer, load pc with the fetch pointer, and set valid=1, giving a latency of one cycle.
REQ-026 In FETCH with stall=0, each edge SHALL then advance the fetch pointer to pointer+1, or to jump_addr if jump=1.
REQ-027 A fetch pointer >= DEPTH SHALL return STOP_WORD; there SHALL be no wrap-around.
REQ-028 When the fetched word is a stop word, it SHALL be presented with valid=1 for one cycle.
REQ-029 After a stop word is presented, the next edge SHALL enter HALT with valid=0 and halted=1.
REQ-030 stall=1 in FETCH SHALL hold instruction, pc, valid and the fetch pointer unchanged.
REQ-031 When stall and jump are both 1, stall SHALL win and jump SHALL be discarded.
REQ-032 run SHALL be ignored while in FETCH.
REQ-033 In IDLE and HALT, instruction and pc SHALL hold their last values and valid SHALL be 0.
REQ-034 prog_we and run both high in IDLE SHALL perform the write and the transition in the same edge; the first fetch SHALL see the new word.

Reset
REQ-035 clear=1 SHALL immediately force state IDLE, instruction=0, pc=0, valid=0, halted=0 and fetch pointer=0, independent of clk.
REQ-036 clear=1 SHALL force every memory word to STOP_WORD.
REQ-037 clear asserted mid-FETCH SHALL abort the fetch.
REQ-038 After clear is released, fetching SHALL resume only after a new run.

Verification
REQ-039 Load words 0..3 = 0x44, 0x49, 0x18, 0xC3, then pulse run -> instruction 0x44/0x49/0x18/0xC3 with pc 0..3 on consecutive cycles, valid=1; next cycle valid=0, halted=1.
REQ-040 Same program, stall=1 for 2 cycles while 0x49 is shown -> 0x49 and pc=1 held 3 cycles, then 0x18 follows.
REQ-041 Program 0x01 at word 0, jump=1 with jump_addr=5 on the first fetch cycle, and 0xC0 at word 5 -> sequence 0x01 (pc 0), 0xC0 (pc 5), then halted.
REQ-042 After clear, run with no programming -> first word 0xC0 at pc 0, then halted=1.
REQ-043 Program words 0..31 all 0x01 (DEPTH=32) -> 32 fetches, then STOP_WORD at pc 32, then halted.
REQ-044 Assert clear during FETCH at pc=2 -> outputs zero asynchronously, memory all 0xC0, state IDLE; prog_we at addr 40 is ignored.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Small instruction store plus sequential fetch engine.
//
// A register-based program memory of DEPTH words is loaded while the engine is
// idle. A run pulse starts fetching from word 0. Every unstalled edge presents
// one word on instruction/pc with valid=1 and moves the fetch pointer either to
// the next word or to jump_addr. Any word whose two MSBs are 2'b11 is a stop
// word: it is shown for one cycle and the engine then parks in HALT.
//
// Ports
//   clk         rising-edge clock
//   clear       asynchronous active-high reset (also fills memory with STOP)
//   prog_we     program-write strobe (honoured only in IDLE)
//   prog_addr   program-write address (writes at or beyond DEPTH are dropped)
//   prog_data   program-write data
//   run         start-fetch pulse (honoured in IDLE and HALT)
//   stall       hold the current fetch
//   jump        redirect the fetch pointer to jump_addr
//   jump_addr   redirect target
//   instruction registered fetched word
//   pc          address of the word on instruction
//   valid       instruction holds a freshly fetched word this cycle
//   halted      a stop word has been fetched and retired
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [WIDTH-1:0]  prog_data,
  input  logic              run,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [WIDTH-1:0]  instruction,
  output logic [ADDR_W-1:0] pc,
  output logic              valid,
  output logic              halted
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] STOP_WORD = {2'b11, {(WIDTH-2){1'b0}}};
  // DEPTH widened by one bit so pointer/address range checks never overflow.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] fp_reg, fp_next;
  logic [WIDTH-1:0]  instr_next;
  logic [ADDR_W-1:0] pc_next;
  logic              valid_next;
  logic              halted_next;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              prog_ok;
  logic              fp_in_range;
  logic              shown_stop;
  logic [WIDTH-1:0]  fetch_word;

  assign prog_ok     = prog_we && (state_reg == IDLE) && ({1'b0, prog_addr} < DEPTH_LIM);
  assign fp_in_range = ({1'b0, fp_reg} < DEPTH_LIM);
  // Past the end of the store the engine sees a stop word, so running off the
  // end of a program terminates cleanly instead of wrapping to word 0.
  assign fetch_word  = fp_in_range ? mem[fp_reg[IDX_W-1:0]] : STOP_WORD;
  assign shown_stop  = valid && (instruction[WIDTH-1 -: 2] == 2'b11);

  // Program store. Clear fills every word with STOP so an unprogrammed run
  // halts on its first fetch.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= STOP_WORD;
      end
    end else if (prog_ok) begin
      mem[prog_addr[IDX_W-1:0]] <= prog_data;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_reg   <= IDLE;
      fp_reg      <= '0;
      instruction <= '0;
      pc          <= '0;
      valid       <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state_reg   <= state_next;
      fp_reg      <= fp_next;
      instruction <= instr_next;
      pc          <= pc_next;
      valid       <= valid_next;
      halted      <= halted_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    fp_next     = fp_reg;
    instr_next  = instruction;
    pc_next     = pc;
    valid_next  = valid;
    halted_next = halted;

    case (state_reg)
      IDLE, HALT: begin
        valid_next = 1'b0;
        if (run) begin
          state_next  = FETCH;
          fp_next     = '0;
          halted_next = 1'b0;
        end
      end

      FETCH: begin
        // A stop word already on the outputs retires the run on this edge,
        // whatever the consumer is asking for.
        if (shown_stop) begin
          state_next  = HALT;
          valid_next  = 1'b0;
          halted_next = 1'b1;
        end else if (!stall) begin
          instr_next = fetch_word;
          pc_next    = fp_reg;
          valid_next = 1'b1;
          if (jump) begin
            fp_next = jump_addr;
          end else if (fp_reg != '1) begin
            // Saturate rather than wrap at the top of the address space.
            fp_next = fp_reg + ADDR_W'(1);
          end
        end
      end

      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Directed scenarios followed by randomized runs, checked every cycle against
// a behavioural model of the fetch engine (program array + run mode + pointer).
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              clear;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [WIDTH-1:0]  prog_data;
  logic              run;
  logic              stall;
  logic              jump;
  logic [ADDR_W-1:0] jump_addr;
  logic [WIDTH-1:0]  instruction;
  logic [ADDR_W-1:0] pc;
  logic              valid;
  logic              halted;

  instr_fetch #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .clear(clear), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .run(run), .stall(stall), .jump(jump),
    .jump_addr(jump_addr), .instruction(instruction), .pc(pc),
    .valid(valid), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- behavioural reference ----------------
  // m_mode: 0 = waiting for run, 1 = running, 2 = finished
  logic [7:0] m_mem [DEPTH];
  int         m_mode;
  int         m_ptr;
  logic [7:0] m_instr;
  logic [7:0] m_pc;
  logic       m_valid;
  logic       m_halted;

  function automatic logic is_stop(input logic [7:0] w);
    return w[7:6] == 2'b11;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'hC0;
    m_mode = 0; m_ptr = 0;
    m_instr = 8'h00; m_pc = 8'h00; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    if (m_mode == 1) begin
      if (m_valid && is_stop(m_instr)) begin
        m_mode = 2; m_valid = 1'b0; m_halted = 1'b1;
      end else if (!stall) begin
        m_instr = (m_ptr < DEPTH) ? m_mem[m_ptr] : 8'hC0;
        m_pc    = 8'(m_ptr);
        m_valid = 1'b1;
        m_ptr   = jump ? int'(jump_addr) : m_ptr + 1;
      end
    end else begin
      if (prog_we && m_mode == 0 && int'(prog_addr) < DEPTH)
        m_mem[int'(prog_addr)] = prog_data;
      m_valid = 1'b0;
      if (run) begin
        m_mode = 1; m_ptr = 0; m_halted = 1'b0;
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".instr"},  32'(instruction), 32'(m_instr));
    chk({tag, ".pc"},     32'(pc),          32'(m_pc));
    chk({tag, ".valid"},  32'(valid),       32'(m_valid));
    chk({tag, ".halted"}, 32'(halted),      32'(m_halted));
  endtask

  task automatic expect_out(input string tag, input logic [7:0] ei, input logic [7:0] ep,
                            input logic ev, input logic eh);
    chk({tag, ".instr"},  32'(instruction), 32'(ei));
    chk({tag, ".pc"},     32'(pc),          32'(ep));
    chk({tag, ".valid"},  32'(valid),       32'(ev));
    chk({tag, ".halted"}, 32'(halted),      32'(eh));
  endtask

  // One clock edge: model follows the DUT, outputs sampled 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic idle_inputs();
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    run = 1'b0; stall = 1'b0; jump = 1'b0; jump_addr = '0;
  endtask

  // Pulse clear between clock edges and confirm the asynchronous effect.
  task automatic do_clear(input string tag);
    #2;
    clear = 1'b1;
    #1;
    model_reset();
    expect_out({tag, ".clr"}, 8'h00, 8'h00, 1'b0, 1'b0);
    #1;
    clear = 1'b0;
  endtask

  task automatic prog(input int a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = 8'(a); prog_data = d;
    step("prog");
    prog_we = 1'b0;
  endtask

  initial begin
    logic [7:0] pd;
    idle_inputs();
    clear = 1'b1;
    #3;
    model_reset();
    expect_out("reset", 8'h00, 8'h00, 1'b0, 1'b0);
    #1 clear = 1'b0;

    // Basic four-word program ending in a stop word.
    prog(0, 8'h44); prog(1, 8'h49); prog(2, 8'h18); prog(3, 8'hC3);
    run = 1'b1; step("run");
    run = 1'b0;
    expect_out("seq.start", 8'h00, 8'h00, 1'b0, 1'b0);
    step("seq"); expect_out("seq.w0", 8'h44, 8'd0, 1'b1, 1'b0);
    step("seq"); expect_out("seq.w1", 8'h49, 8'd1, 1'b1, 1'b0);
    step("seq"); expect_out("seq.w2", 8'h18, 8'd2, 1'b1, 1'b0);
    step("seq"); expect_out("seq.w3", 8'hC3, 8'd3, 1'b1, 1'b0);
    step("seq"); expect_out("seq.halt", 8'hC3, 8'd3, 1'b0, 1'b1);

    // Rerun from HALT with a two-cycle stall on word 1; stall beats jump.
    run = 1'b1; step("rerun");
    run = 1'b0;
    step("st"); expect_out("st.w0", 8'h44, 8'd0, 1'b1, 1'b0);
    step("st"); expect_out("st.w1", 8'h49, 8'd1, 1'b1, 1'b0);
    stall = 1'b1; jump = 1'b1; jump_addr = 8'd30;
    step("st"); expect_out("st.hold1", 8'h49, 8'd1, 1'b1, 1'b0);
    jump = 1'b0;
    step("st"); expect_out("st.hold2", 8'h49, 8'd1, 1'b1, 1'b0);
    stall = 1'b0;
    step("st"); expect_out("st.w2", 8'h18, 8'd2, 1'b1, 1'b0);
    step("st"); step("st"); expect_out("st.halt", 8'hC3, 8'd3, 1'b0, 1'b1);

    // Jump on the first fetch cycle.
    do_clear("jmp");
    prog(0, 8'h01); prog(5, 8'hC0);
    run = 1'b1; step("jmp");
    run = 1'b0; jump = 1'b1; jump_addr = 8'd5;
    step("jmp"); expect_out("jmp.w0", 8'h01, 8'd0, 1'b1, 1'b0);
    jump = 1'b0;
    step("jmp"); expect_out("jmp.w5", 8'hC0, 8'd5, 1'b1, 1'b0);
    step("jmp"); expect_out("jmp.halt", 8'hC0, 8'd5, 1'b0, 1'b1);

    // Unprogrammed memory after clear; run together with a write in the same edge.
    do_clear("empty");
    run = 1'b1; step("empty");
    run = 1'b0;
    step("empty"); expect_out("empty.w0", 8'hC0, 8'd0, 1'b1, 1'b0);
    step("empty"); expect_out("empty.halt", 8'hC0, 8'd0, 1'b0, 1'b1);
    do_clear("same");
    prog_we = 1'b1; prog_addr = 8'd0; prog_data = 8'h2A; run = 1'b1;
    step("same");
    prog_we = 1'b0; run = 1'b0;
    step("same"); expect_out("same.w0", 8'h2A, 8'd0, 1'b1, 1'b0);

    // Full store of non-stop words runs off the end without wrapping.
    do_clear("full");
    for (int i = 0; i < DEPTH; i++) prog(i, 8'h01);
    run = 1'b1; step("full");
    run = 1'b0;
    for (int i = 0; i < DEPTH; i++) step("full");
    expect_out("full.w31", 8'h01, 8'd31, 1'b1, 1'b0);
    step("full"); expect_out("full.end", 8'hC0, 8'd32, 1'b1, 1'b0);
    step("full"); expect_out("full.halt", 8'hC0, 8'd32, 1'b0, 1'b1);

    // Abort mid-fetch; out-of-range write must not alias onto word 8.
    do_clear("abort");
    for (int i = 0; i < 8; i++) prog(i, 8'h11);
    run = 1'b1; step("abort");
    run = 1'b0;
    step("abort"); step("abort"); step("abort");
    expect_out("abort.pc2", 8'h11, 8'd2, 1'b1, 1'b0);
    do_clear("abort");
    run = 1'b1; step("abort");
    run = 1'b0;
    step("abort"); expect_out("abort.memclr", 8'hC0, 8'd0, 1'b1, 1'b0);
    do_clear("alias");
    for (int i = 0; i < 8; i++) prog(i, 8'h11);
    prog(40, 8'h05);
    run = 1'b1; step("alias");
    run = 1'b0;
    for (int i = 0; i < 9; i++) step("alias");
    expect_out("alias.w8", 8'hC0, 8'd8, 1'b1, 1'b0);
    step("alias");

    // Randomized runs: writes during FETCH/HALT, run in FETCH, stalls, jumps.
    for (int r = 0; r < 6; r++) begin
      do_clear("rnd");
      idle_inputs();
      for (int k = 0; k < 24; k++) begin
        pd = 8'($urandom);
        if (pd[7:6] == 2'b11 && $urandom_range(0, 3) != 0) pd[6] = 1'b0;
        prog(int'($urandom_range(0, 39)), pd);
      end
      for (int c = 0; c < 160; c++) begin
        run       = ($urandom_range(0, 7) == 0);
        stall     = ($urandom_range(0, 3) == 0);
        jump      = ($urandom_range(0, 5) == 0);
        jump_addr = 8'($urandom_range(0, 40));
        prog_we   = ($urandom_range(0, 5) == 0);
        prog_addr = 8'($urandom_range(0, 39));
        prog_data = 8'($urandom);
        step("rnd");
        if (c == 80 && r[0]) do_clear("rnd");
      end
      idle_inputs();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
